// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind the core's data port, with
// byte-lane alignment of stores/loads and programmable read wait states.
// Optional feature macro: DMEM_RANDWAIT_EN -- replaces the fixed wait count
// with an 8-bit LFSR value masked by WAIT_MASK.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [7:0]  WAIT_MASK   = 8'h03,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic        mem_oe,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic [15:0] rd_count
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  logic [31:0]       mem [Depth];
  state_e            state_q;
  logic [7:0]        cnt_q;
  logic [7:0]        wait_val;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        off;
  logic [7:0]        lanes_wide;
  logic [3:0]        lanes;
  logic [31:0]       wdata_sh;
  logic [31:0]       rword;
  logic [31:0]       rdata_sh;
  logic              is_read;
  logic              is_write;
  logic              unused_addr;

  // Upper address bits alias onto the RAM.
  assign unused_addr = ^{mem_addr[31:ADDR_W+2]};

  assign widx       = mem_addr[ADDR_W+1:2];
  assign off        = mem_addr[1:0];
  // Lanes pushed past bit 3 fall off: misaligned stores write only the in-word part.
  assign lanes_wide = {4'b0000, mem_we} << off;
  assign lanes      = lanes_wide[3:0];
  assign wdata_sh   = mem_wdata << {off, 3'b000};
  assign rword      = mem[widx];
  assign rdata_sh   = rword >> {off, 3'b000};

  // Requests are only decoded in IDLE; BUSY/DONE see the core's re-presented load.
  assign is_read  = mem_oe && (mem_we == 4'b0000) && (state_q == StIdle);
  assign is_write = mem_oe && (mem_we != 4'b0000) && (state_q == StIdle);

`ifdef DMEM_RANDWAIT_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  // Fibonacci LFSR, taps 8,6,5,4; advances once per accepted read.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else if (is_read) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end

  // Wait uses the value before the advance.
  assign wait_val = lfsr_q & WAIT_MASK;
`else
  logic [7:0] unused_wait_mask;
  assign unused_wait_mask = WAIT_MASK;
  assign wait_val         = 8'(WAIT_CYCLES);
`endif

  // Byte-lane RAM write, committed at the accepting edge (contents not reset).
  always_ff @(posedge clk) begin
    if (is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  // Read FSM with registered ready/rdata/count outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      mem_ready <= 1'b1;
      mem_rdata <= 32'd0;
      rd_count  <= 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_read) begin
            mem_rdata <= rdata_sh;
            rd_count  <= rd_count + 16'd1;
            if (wait_val != 8'd0) begin
              state_q   <= StBusy;
              cnt_q     <= wait_val;
              mem_ready <= 1'b0;
            end
          end
        end
        StBusy: begin
          if (cnt_q == 8'd1) begin
            state_q   <= StDone;
            cnt_q     <= 8'd0;
            mem_ready <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StDone: begin
          // The request seen here is the held duplicate of the completed load.
          state_q <= StIdle;
        end
        default: begin
          state_q   <= StIdle;
          mem_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
